// File: rtl/hex_stream_encoder.sv
// Hex-dump serializer: takes one NBR_OF_NIBBLES-nibble word over valid/ready and
// streams it out as ASCII bytes (optional "0x" prefix, MSB nibble first, optional terminator).
module hex_stream_encoder #(
    parameter int unsigned NBR_OF_NIBBLES = 4,
    parameter int unsigned LOWERCASE      = 0,
    parameter int unsigned EMIT_PREFIX    = 1,
    parameter int unsigned TERMINATOR     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NBR_OF_NIBBLES*4-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [7:0]                  out_char,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int unsigned DATA_W = NBR_OF_NIBBLES * 4;
    localparam int unsigned CNT_W  = (NBR_OF_NIBBLES > 1) ? $clog2(NBR_OF_NIBBLES) : 1;

    localparam logic [7:0] ALPHA_BASE = (LOWERCASE != 0) ? 8'h61 : 8'h41;
    localparam logic [7:0] TERM0_CHAR = (TERMINATOR == 1) ? 8'h20 : 8'h0D;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;
    localparam logic [7:0] CHAR_X     = 8'h78;
    localparam logic [7:0] CHAR_LF    = 8'h0A;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PFX0  = 3'd1,
        PFX1  = 3'd2,
        DIGIT = 3'd3,
        TERM0 = 3'd4,
        TERM1 = 3'd5
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  word_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         out_char_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic               busy_q;
    logic               consume_c;
    logic               last_byte_c;

    function automatic logic [7:0] enc(input logic [3:0] n);
        if (n < 4'd10) begin
            return CHAR_ZERO + 8'(n);
        end
        return ALPHA_BASE + 8'(n) - 8'd10;
    endfunction

    function automatic logic [3:0] nibble_at(input logic [DATA_W-1:0] w,
                                             input logic [CNT_W-1:0]  idx);
        return 4'(w >> {idx, 2'b00});
    endfunction

    assign consume_c = out_valid_q && out_ready;

    // The byte currently on out_char is the final one of the word.
    assign last_byte_c = ((state_q == DIGIT) && (cnt_q == '0) && (TERMINATOR == 0))
                      || ((state_q == TERM0) && (TERMINATOR != 2))
                      || (state_q == TERM1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            cnt_q       <= '0;
            out_char_q  <= 8'h00;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else if (state_q == IDLE) begin
            if (in_valid && in_ready_q) begin
                word_q      <= in_data;
                cnt_q       <= CNT_W'(NBR_OF_NIBBLES - 1);
                out_valid_q <= 1'b1;
                in_ready_q  <= 1'b0;
                busy_q      <= 1'b1;
                if (EMIT_PREFIX != 0) begin
                    state_q    <= PFX0;
                    out_char_q <= CHAR_ZERO;
                end else begin
                    state_q    <= DIGIT;
                    out_char_q <= enc(in_data[DATA_W-1 -: 4]);
                end
            end
        end else if (consume_c) begin
            if (last_byte_c) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b1;
                busy_q      <= 1'b0;
            end else begin
                // Load the following byte on the consuming edge so bytes stream back-to-back.
                case (state_q)
                    PFX0: begin
                        state_q    <= PFX1;
                        out_char_q <= CHAR_X;
                    end
                    PFX1: begin
                        state_q    <= DIGIT;
                        out_char_q <= enc(word_q[DATA_W-1 -: 4]);
                    end
                    DIGIT: begin
                        if (cnt_q != '0) begin
                            cnt_q      <= cnt_q - CNT_W'(1);
                            out_char_q <= enc(nibble_at(word_q, cnt_q - CNT_W'(1)));
                        end else begin
                            state_q    <= TERM0;
                            out_char_q <= TERM0_CHAR;
                        end
                    end
                    TERM0: begin
                        state_q    <= TERM1;
                        out_char_q <= CHAR_LF;
                    end
                    default: begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_char  = out_char_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
